// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - picorv32 native bus to NUM_SLAVES interconnect with address decode, timeout and error log
module mem_bus_fabric #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_MSB    = 31,
    parameter int          SEL_LSB    = 28,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic                     err_clear,
    output logic                     bus_error,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
    logic                    mem_ready_q, mem_ready_d;
    logic [31:0]             mem_rdata_q, mem_rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    bus_error_q, bus_error_d;
    logic [31:0]             err_addr_q, err_addr_d;
    logic [7:0]              err_count_q, err_count_d;

    logic [31:0]             sel_ext;
    logic                    sel_hit;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic                    slave_ready;
    logic [31:0]             slave_rdata;
    logic                    err_event;

    assign s_addr  = mem_addr;
    assign s_wdata = mem_wdata;
    assign s_wstrb = mem_wstrb;

    // The latched one-hot s_valid_q doubles as the selection register.
    always_comb begin
        sel_ext     = 32'(mem_addr[SEL_MSB:SEL_LSB]);
        sel_hit     = (sel_ext < 32'(NUM_SLAVES));
        sel_onehot  = '0;
        slave_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot[i] = (sel_ext == 32'(i));
            if (s_valid_q[i]) begin
                slave_rdata = s_rdata[32*i +: 32];
            end
        end
        slave_ready = |(s_ready & s_valid_q);
    end

    always_comb begin
        state_d     = state_q;
        s_valid_d   = s_valid_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        cnt_d       = cnt_q;
        err_event   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_valid && !mem_ready_q) begin
                    if (sel_hit) begin
                        state_d   = ACTIVE;
                        s_valid_d = sel_onehot;
                    end else begin
                        state_d     = RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = ERR_DATA;
                        err_event   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_valid) begin
                    state_d   = IDLE;
                    s_valid_d = '0;
                    cnt_d     = '0;
                end else if (slave_ready) begin
                    state_d     = RESP;
                    s_valid_d   = '0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = slave_rdata;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d     = RESP;
                    s_valid_d   = '0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ERR_DATA;
                    err_event   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d   = IDLE;
                s_valid_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    // A new error outranks a simultaneous clear, restarting the count at one.
    always_comb begin
        bus_error_d = bus_error_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (err_event) begin
            bus_error_d = 1'b1;
            err_addr_d  = mem_addr;
            if (err_clear) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (err_clear) begin
            bus_error_d = 1'b0;
            err_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_valid_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_valid_q   <= s_valid_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign s_valid   = s_valid_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_error = bus_error_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb/tb_mem_bus_fabric.sv - scoreboard bench for mem_bus_fabric with directed vectors
module tb_mem_bus_fabric;
    logic         clk = 1'b0;
    logic         resetn;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_clear;
    logic         bus_error;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    mem_bus_fabric #(
        .NUM_SLAVES(4), .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err_clear(err_clear),
        .bus_error(bus_error), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // Slave models: latency 255 means the slave never answers.
    logic [7:0]  lat [4];
    logic [31:0] sdata [4];
    logic [7:0]  scnt [4];
    logic [31:0] cap_wdata [4];
    logic [3:0]  cap_wstrb [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_ready[i] = s_valid[i] && (lat[i] != 8'd255) && (scnt[i] == lat[i]);
            s_rdata[32*i +: 32] = sdata[i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (s_valid[i] && !s_ready[i]) scnt[i] <= scnt[i] + 8'd1;
            else                           scnt[i] <= 8'd0;
            if (s_valid[i] && s_ready[i]) begin
                cap_wdata[i] <= s_wdata;
                cap_wstrb[i] <= s_wstrb;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the fabric acknowledges.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            checks++;
            if ($countones(s_valid) > 1) begin
                failures++;
                $display("FAIL onehot: s_valid=%b", s_valid);
            end
            if (mem_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready: rdata=0x%08h with no pending transfer", mem_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (mem_rdata !== e.rdata) begin
                        failures++;
                        $display("FAIL rdata: got 0x%08h expected 0x%08h", mem_rdata, e.rdata);
                    end
                    checks++;
                    if (cyc - start_cyc != e.lat) begin
                        failures++;
                        $display("FAIL latency: got %0d expected %0d", cyc - start_cyc, e.lat);
                    end
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [3:0] exp_sv, input logic [31:0] exp_rdata, input int exp_lat,
                        input int exp_svc, input logic clr);
        logic [3:0] sv_seen;
        int         svc;
        bit         done;
        exp_t       e;
        sv_seen = '0;
        svc     = 0;
        done    = 0;
        e.rdata = exp_rdata;
        e.lat   = exp_lat;
        @(posedge clk); #1;
        exp_q.push_back(e);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        err_clear = clr;
        start_cyc = cyc;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            err_clear = 1'b0;
            sv_seen |= s_valid;
            if (s_valid != 4'b0) svc++;
            if (mem_ready) done = 1;
        end
        mem_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout_wait: no mem_ready for addr 0x%08h", addr);
            void'(exp_q.pop_back());
        end
        chk("s_valid_seen", {28'd0, sv_seen}, {28'd0, exp_sv});
        chk("s_valid_cycles", svc, exp_svc);
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        chk({tag, "_s_valid"}, {28'd0, s_valid}, 32'd0);
        chk({tag, "_bus_error"}, {31'd0, bus_error}, 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        lat[0] = 8'd1;   sdata[0] = 32'h1234_5678;
        lat[1] = 8'd1;   sdata[1] = 32'h1111_0000;
        lat[2] = 8'd255; sdata[2] = 32'h2222_2222;
        lat[3] = 8'd0;   sdata[3] = 32'h3333_3333;
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_state("reset");
        resetn = 1'b1;

        xfer(32'h0000_0010, 32'h0, 4'h0, 4'b0001, 32'h1234_5678, 3, 2, 1'b0);
        chk("read0_bus_error", {31'd0, bus_error}, 32'd0);

        xfer(32'h1000_0000, 32'h0000_00A5, 4'b0001, 4'b0010, 32'h1111_0000, 3, 2, 1'b0);
        chk("write1_wdata", cap_wdata[1], 32'h0000_00A5);
        chk("write1_wstrb", {28'd0, cap_wstrb[1]}, 32'd1);

        xfer(32'h3000_0004, 32'h0, 4'h0, 4'b1000, 32'h3333_3333, 2, 1, 1'b0);

        xfer(32'h5000_0000, 32'h0, 4'h0, 4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b0);
        chk("unmapped_bus_error", {31'd0, bus_error}, 32'd1);
        chk("unmapped_err_addr", err_addr, 32'h5000_0000);
        chk("unmapped_err_count", {24'd0, err_count}, 32'd1);

        xfer(32'h2000_0000, 32'h0, 4'h0, 4'b0100, 32'hDEAD_BEEF, 9, 8, 1'b0);
        chk("hung1_err_count", {24'd0, err_count}, 32'd2);
        chk("hung1_err_addr", err_addr, 32'h2000_0000);
        xfer(32'h2000_0040, 32'h0, 4'h0, 4'b0100, 32'hDEAD_BEEF, 9, 8, 1'b0);
        chk("hung2_err_count", {24'd0, err_count}, 32'd3);

        xfer(32'hF000_0000, 32'h0, 4'h0, 4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b1);
        chk("clr_err_bus_error", {31'd0, bus_error}, 32'd1);
        chk("clr_err_count", {24'd0, err_count}, 32'd1);
        chk("clr_err_addr", err_addr, 32'hF000_0000);
        @(posedge clk); #1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        chk("clr_bus_error", {31'd0, bus_error}, 32'd0);
        chk("clr_err_count", {24'd0, err_count}, 32'd0);
        chk("clr_err_addr_kept", err_addr, 32'hF000_0000);

        // Abort: core withdraws its request while slave 2 is stalled.
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 32'h2000_0008; mem_wstrb = 4'h0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_active_s_valid", {28'd0, s_valid}, 32'h4);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_s_valid", {28'd0, s_valid}, 32'd0);
        chk("abort_err_count", {24'd0, err_count}, 32'd0);
        xfer(32'h0000_0020, 32'h0, 4'h0, 4'b0001, 32'h1234_5678, 3, 2, 1'b0);

        // Reset while ACTIVE, with a logged error present.
        xfer(32'h7000_0000, 32'h0, 4'h0, 4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 32'h2000_0000;
        @(posedge clk); #1;
        chk("rst_active_s_valid", {28'd0, s_valid}, 32'h4);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk_zero_state("rst_active");
        mem_valid = 1'b0; resetn = 1'b1;

        for (int n = 0; n < 256; n++) begin
            xfer(32'h8000_0000 + 32'(n), 32'h0, 4'h0, 4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b0);
        end
        chk("sat_err_count_255", {24'd0, err_count}, 32'd255);
        xfer(32'h9000_0000, 32'h0, 4'h0, 4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b0);
        chk("sat_err_count_hold", {24'd0, err_count}, 32'd255);
        chk("sat_err_addr", err_addr, 32'h9000_0000);
        @(posedge clk); #1; resetn = 1'b0;
        @(posedge clk); #1;
        chk_zero_state("rst_sat");
        resetn = 1'b1;

        xfer(32'h3000_0000, 32'h0, 4'h0, 4'b1000, 32'h3333_3333, 2, 1, 1'b0);
        repeat (4) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
